// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch direction predictor: counter states,
// sweep FSM states and the instruction-alignment offset.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int PC_LSB = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != ST) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != SNT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// 2-bit saturating counter table: reset sweep, combinational read port and a
// single write port shared by the sweep and the resolve-time update.
module bp_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_BITS   = 6,
    parameter logic [1:0] INIT_STATE = WNT
) (
    input  logic                clk,
    input  logic                i_srst,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic [1:0]          o_rd_ctr,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic                i_wr_en,
    input  logic                i_wr_taken,
    output logic                o_ready
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [1:0]          r_mem [DEPTH];
    bp_state_t           r_state_reg;
    bp_state_t           w_state_next;
    logic [IDX_BITS-1:0] r_idx_reg;
    logic [IDX_BITS-1:0] w_idx_next;
    logic                w_we;
    logic [IDX_BITS-1:0] w_wa;
    logic [1:0]          w_wd;
    logic [1:0]          w_cur;

    // Read happens before the edge, so a same-index write is never bypassed.
    assign o_rd_ctr = r_mem[i_rd_idx];
    assign w_cur    = r_mem[i_wr_idx];
    assign o_ready  = (r_state_reg == ST_RUN);

    always_comb begin
        w_state_next = r_state_reg;
        w_idx_next   = r_idx_reg;
        w_we         = 1'b0;
        w_wa         = i_wr_idx;
        w_wd         = ctr_update(w_cur, i_wr_taken);
        case (r_state_reg)
            ST_INIT: begin
                w_we       = 1'b1;
                w_wa       = r_idx_reg;
                w_wd       = INIT_STATE;
                w_idx_next = r_idx_reg + 1'b1;
                if (&r_idx_reg) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_we = i_wr_en;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_state_reg <= ST_INIT;
            r_idx_reg   <= '0;
        end else begin
            r_state_reg <= w_state_next;
            r_idx_reg   <= w_idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && !i_srst) begin
            r_mem[w_wa] <= w_wd;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch direction predictor top: indexing, target/fall-through selection.
// Define BP_GSHARE_EN to XOR a global history register into both indices.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_BITS   = 6,
    parameter logic [1:0] INIT_STATE = WNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    input  logic [31:0] lookup_target,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    output logic        ready,
    output logic        predict_taken,
    output logic [31:0] predict_target
);

    logic [IDX_BITS-1:0] w_lookup_idx;
    logic [IDX_BITS-1:0] w_resolve_idx;
    logic [1:0]          w_ctr;
    logic                w_ready;
    logic                w_unused;

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] r_ghr;

    // Update index uses the history before this resolve shifts into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (resolve_valid && w_ready) begin
            r_ghr <= {r_ghr[IDX_BITS-2:0], resolve_taken};
        end
    end

    assign w_lookup_idx  = lookup_pc[IDX_BITS+PC_LSB-1:PC_LSB] ^ r_ghr;
    assign w_resolve_idx = resolve_pc[IDX_BITS+PC_LSB-1:PC_LSB] ^ r_ghr;
`else
    assign w_lookup_idx  = lookup_pc[IDX_BITS+PC_LSB-1:PC_LSB];
    assign w_resolve_idx = resolve_pc[IDX_BITS+PC_LSB-1:PC_LSB];
`endif

    assign w_unused = ^{resolve_pc[31:IDX_BITS+PC_LSB], resolve_pc[PC_LSB-1:0]};

    bp_counter_table #(
        .IDX_BITS   (IDX_BITS),
        .INIT_STATE (INIT_STATE)
    ) u_table (
        .clk        (clk),
        .i_srst     (reset),
        .i_rd_idx   (w_lookup_idx),
        .o_rd_ctr   (w_ctr),
        .i_wr_idx   (w_resolve_idx),
        .i_wr_en    (resolve_valid),
        .i_wr_taken (resolve_taken),
        .o_ready    (w_ready)
    );

    assign ready          = w_ready;
    assign predict_taken  = w_ready & lookup_valid & w_ctr[1];
    assign predict_target = predict_taken ? lookup_target : (lookup_pc + 32'd4);

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default build, IDX_BITS=6).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic [31:0] lookup_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic        ready;
    logic        predict_taken;
    logic [31:0] predict_target;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .lookup_target  (lookup_target),
        .resolve_valid  (resolve_valid),
        .resolve_pc     (resolve_pc),
        .resolve_taken  (resolve_taken),
        .ready          (ready),
        .predict_taken  (predict_taken),
        .predict_target (predict_target)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken);
        resolve_valid = 1'b1;
        resolve_pc    = pc;
        resolve_taken = taken;
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic exp_t);
        lookup_valid  = 1'b1;
        lookup_pc     = pc;
        lookup_target = tgt;
        #1;
        chk({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
        chk({tag, "_target"}, predict_target, exp_t ? tgt : pc + 32'd4);
        lookup_valid = 1'b0;
    endtask

    // Counts cycles until ready rises; lookups (and ignored resolves) run meanwhile.
    task automatic sweep(input string tag);
        int          cnt;
        logic [31:0] pc;
        cnt = 0;
        while (!ready && cnt < 200) begin
            pc            = 32'h1000 + cnt * 4;
            lookup_valid  = 1'b1;
            lookup_pc     = pc;
            lookup_target = 32'hDEAD_0000;
            resolve_valid = 1'b1;
            resolve_pc    = 32'h0000_00C8;
            resolve_taken = 1'b1;
            #1;
            if (predict_taken !== 1'b0 || predict_target !== pc + 32'd4) begin
                chk({tag, "_init_pred"}, {predict_taken, predict_target[30:0]},
                    {1'b0, pc[30:0] + 31'd4});
            end
            tick();
            cnt++;
        end
        lookup_valid  = 1'b0;
        resolve_valid = 1'b0;
        chk({tag, "_len"}, cnt, 32'd64);
    endtask

    initial begin
        reset         = 1'b1;
        lookup_valid  = 1'b0;
        lookup_pc     = '0;
        lookup_target = '0;
        resolve_valid = 1'b0;
        resolve_pc    = '0;
        resolve_taken = 1'b0;

        repeat (3) tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        look("rst_look", 32'h0000_0010, 32'h0000_0080, 1'b0);
        reset = 1'b0;
        sweep("sweep1");
        chk("run_ready", {31'd0, ready}, 32'd1);
        look("init_resolve_ignored", 32'h0000_00C8, 32'h0000_0400, 1'b0);

        resolve(32'h100, 1'b1);
        resolve(32'h100, 1'b1);
        look("train_100", 32'h100, 32'h180, 1'b1);
        look("train_104", 32'h104, 32'h200, 1'b0);

        repeat (5) resolve(32'h200, 1'b1);
        resolve(32'h200, 1'b0);
        look("sat_1nt", 32'h200, 32'h300, 1'b1);
        repeat (2) resolve(32'h200, 1'b0);
        look("sat_3nt", 32'h200, 32'h300, 1'b0);
        repeat (10) resolve(32'h200, 1'b0);
        resolve(32'h200, 1'b1);
        look("sat_1t", 32'h200, 32'h300, 1'b0);
        resolve(32'h200, 1'b1);
        look("sat_2t", 32'h200, 32'h300, 1'b1);

        // Same-cycle lookup and resolve on a WNT entry.
        lookup_valid  = 1'b1;
        lookup_pc     = 32'h40;
        lookup_target = 32'h90;
        resolve_valid = 1'b1;
        resolve_pc    = 32'h40;
        resolve_taken = 1'b1;
        #1;
        chk("hazard_same", {31'd0, predict_taken}, 32'd0);
        tick();
        resolve_valid = 1'b0;
        look("hazard_next", 32'h40, 32'h90, 1'b1);

        look("wrap", 32'hFFFF_FFFC, 32'h1234, 1'b0);
        resolve(32'h000, 1'b1);
        look("alias_100", 32'h100, 32'h500, 1'b1);
        lookup_valid  = 1'b0;
        lookup_pc     = 32'h100;
        lookup_target = 32'h500;
        #1;
        chk("novalid_taken", {31'd0, predict_taken}, 32'd0);
        chk("novalid_target", predict_target, 32'h104);

        reset = 1'b1;
        tick();
        chk("runrst_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        chk("midsweep_ready", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep("sweep2");
        look("post_rst_100", 32'h100, 32'h180, 1'b0);
        look("post_rst_40", 32'h40, 32'h90, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
